// File: rtl/mul_div_unit_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// The flush_mdu_i member exists only when MDU_FLUSH_EN is defined.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_mdu_i;
  logic [1:0]       op_mdu_i;
  logic [WIDTH-1:0] opr_a_mdu_i;
  logic [WIDTH-1:0] opr_b_mdu_i;
`ifdef MDU_FLUSH_EN
  logic             flush_mdu_i;
`endif
  logic             ready_mdu_o;
  logic             done_mdu_o;
  logic             dz_mdu_o;
  logic [WIDTH-1:0] hi_mdu_o;
  logic [WIDTH-1:0] lo_mdu_o;

`ifdef MDU_FLUSH_EN
  modport master (
    output start_mdu_i, op_mdu_i,
    output opr_a_mdu_i, opr_b_mdu_i,
    output flush_mdu_i,
    input  ready_mdu_o, done_mdu_o,
    input  dz_mdu_o, hi_mdu_o, lo_mdu_o
  );
  modport slave (
    input  start_mdu_i, op_mdu_i,
    input  opr_a_mdu_i, opr_b_mdu_i,
    input  flush_mdu_i,
    output ready_mdu_o, done_mdu_o,
    output dz_mdu_o, hi_mdu_o, lo_mdu_o
  );
`else
  modport master (
    output start_mdu_i, op_mdu_i,
    output opr_a_mdu_i, opr_b_mdu_i,
    input  ready_mdu_o, done_mdu_o,
    input  dz_mdu_o, hi_mdu_o, lo_mdu_o
  );
  modport slave (
    input  start_mdu_i, op_mdu_i,
    input  opr_a_mdu_i, opr_b_mdu_i,
    output ready_mdu_o, done_mdu_o,
    output dz_mdu_o, hi_mdu_o, lo_mdu_o
  );
`endif
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO, one bit per cycle.
// Optional abort input enabled by defining MDU_FLUSH_EN.
module mul_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic            clk_mdu_i,
  input logic            rst_n_mdu_i,
  mul_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic             neg_q;
  logic             neg_r_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dz_q;

  logic             flush;
  logic             accept;
  logic             fix_act;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef MDU_FLUSH_EN
  assign flush = bus.flush_mdu_i;
`else
  assign flush = 1'b0;
`endif

  assign accept  = bus.start_mdu_i && (state_q == S_IDLE);
  assign fix_act = (state_q == S_FIX) && !flush;

  assign a_neg = !bus.op_mdu_i[0] && bus.opr_a_mdu_i[WIDTH-1];
  assign b_neg = !bus.op_mdu_i[0] && bus.opr_b_mdu_i[WIDTH-1];
  assign a_mag = a_neg ? -bus.opr_a_mdu_i : bus.opr_a_mdu_i;
  assign b_mag = b_neg ? -bus.opr_b_mdu_i : bus.opr_b_mdu_i;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] quot_n;

  always_comb begin
    mul_sum = acc_q + (quot_q[0] ? {1'b0, b_q} : '0);
    rem_s   = {acc_q[WIDTH-1:0], quot_q[WIDTH-1]};
    trial   = rem_s - {1'b0, b_q};
    ge      = rem_s >= {1'b0, b_q};
    acc_n   = acc_q;
    quot_n  = quot_q;
    if (state_q == S_MUL) begin
      acc_n  = {1'b0, mul_sum[WIDTH:1]};
      quot_n = {mul_sum[0], quot_q[WIDTH-1:1]};
    end else if (state_q == S_DIV) begin
      acc_n  = ge ? trial : rem_s;
      quot_n = {quot_q[WIDTH-2:0], ge};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0]   q_f, r_f;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fix_dz;

  always_comb begin
    prod   = {acc_q[WIDTH-1:0], quot_q};
    prod_f = neg_q ? -prod : prod;
    q_f    = neg_q ? -quot_q : quot_q;
    r_f    = neg_r_q ? -acc_q[WIDTH-1:0]
                     : acc_q[WIDTH-1:0];
    fix_dz = op_q[1] && (b_q == '0);
    fix_hi = prod_f[2*WIDTH-1:WIDTH];
    fix_lo = prod_f[WIDTH-1:0];
    if (fix_dz) begin
      // Divide by zero reports the raw dividend.
      fix_hi = a_q;
      fix_lo = '1;
    end else if (op_q[1]) begin
      fix_hi = r_f;
      fix_lo = q_f;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_mdu_i)
          state_d = bus.op_mdu_i[1] ? S_DIV : S_MUL;
      end
      S_MUL, S_DIV: begin
        if (cnt_q == CNT_W'(1))
          state_d = S_FIX;
      end
      S_FIX: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE))
      state_d = S_IDLE;
  end

  always_ff @(posedge clk_mdu_i or negedge rst_n_mdu_i) begin
    if (!rst_n_mdu_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      quot_q  <= '0;
      b_q     <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.op_mdu_i;
        neg_q   <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        cnt_q   <= CNT_W'(WIDTH);
        acc_q   <= '0;
        quot_q  <= a_mag;
        b_q     <= b_mag;
        a_q     <= bus.opr_a_mdu_i;
        dz_q    <= 1'b0;
      end else if ((state_q == S_MUL) ||
                   (state_q == S_DIV)) begin
        acc_q  <= acc_n;
        quot_q <= quot_n;
        cnt_q  <= cnt_q - CNT_W'(1);
      end
      if (fix_act) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
        dz_q <= fix_dz;
      end
    end
  end

  // Results are visible in the same cycle as the done pulse.
  assign bus.ready_mdu_o = (state_q == S_IDLE);
  assign bus.done_mdu_o  = fix_act;
  assign bus.hi_mdu_o    = fix_act ? fix_hi : hi_q;
  assign bus.lo_mdu_o    = fix_act ? fix_lo : lo_q;
  assign bus.dz_mdu_o    = fix_act ? fix_dz : dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, corner
// sequences and randomized ops against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_mdu_i   (clk),
    .rst_n_mdu_i (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi,
                                output logic [31:0] lo,
                                output logic dz);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     p;
    dz = 1'b0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          p  = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          p = {32'(sa % sb), 32'(sa / sb)};
        end else begin
          p = {32'(ua % ub), 32'(ua / ub)};
        end
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // Returns at the negedge of the done cycle; lat counts negedges
  // after the accept edge, rdy_low counts busy cycles seen.
  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit hold,
                        output logic [31:0] hi,
                        output logic [31:0] lo,
                        output logic dz,
                        output int lat,
                        output int rdy_low);
    int guard;
    bit seen;
    @(negedge clk);
    guard = 0;
    while (!bus.ready_mdu_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.start_mdu_i = 1'b1;
    bus.op_mdu_i    = op;
    bus.opr_a_mdu_i = a;
    bus.opr_b_mdu_i = b;
    @(posedge clk);
    lat = 0;
    rdy_low = 0;
    seen = 1'b0;
    hi = '0;
    lo = '0;
    dz = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!hold) begin
        bus.start_mdu_i = 1'b0;
        bus.opr_a_mdu_i = $urandom;
        bus.opr_b_mdu_i = $urandom;
      end
      lat++;
      if (!bus.ready_mdu_o) rdy_low++;
      if (bus.done_mdu_o) begin
        hi = bus.hi_mdu_o;
        lo = bus.lo_mdu_o;
        dz = bus.dz_mdu_o;
        seen = 1'b1;
        break;
      end
    end
    bus.start_mdu_i = 1'b0;
    if (!seen) lat = -1;
  endtask

  vec_t        tbl[$];
  logic [31:0] hi, lo, ehi, elo;
  logic        dz, edz;
  int          lat, rl;
  int          dn;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start_mdu_i = 1'b0;
    bus.op_mdu_i    = '0;
    bus.opr_a_mdu_i = '0;
    bus.opr_b_mdu_i = '0;
`ifdef MDU_FLUSH_EN
    bus.flush_mdu_i = 1'b0;
`endif

    tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    tbl.push_back('{2'b00, 32'hFFFF_FFF9, 32'd3,
                    32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    tbl.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    tbl.push_back('{2'b11, 32'd7, 32'd2,
                    32'd1, 32'd3, 1'b0});
    tbl.push_back('{2'b11, 32'h1234, 32'd0,
                    32'h1234, 32'hFFFF_FFFF, 1'b1});
    tbl.push_back('{2'b10, MIN, 32'hFFFF_FFFF,
                    32'd0, MIN, 1'b0});
    tbl.push_back('{2'b00, MIN, MIN,
                    32'h4000_0000, 32'd0, 1'b0});
    tbl.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE,
                    32'd1, 32'hFFFF_FFFD, 1'b0});
    tbl.push_back('{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD,
                    32'hFFFF_FFFE, 32'd2, 1'b0});
    tbl.push_back('{2'b10, 32'hFFFF_FFFB, 32'd0,
                    32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1});
    tbl.push_back('{2'b01, MIN, 32'd2,
                    32'd1, 32'd0, 1'b0});

    #1;
    chk("rst_ready", bus.ready_mdu_o, 1);
    chk("rst_done", bus.done_mdu_o, 0);
    chk("rst_dz", bus.dz_mdu_o, 0);
    chk("rst_hi", bus.hi_mdu_o, 0);
    chk("rst_lo", bus.lo_mdu_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0,
             hi, lo, dz, lat, rl);
      chk($sformatf("tbl%0d_lat", i), lat, W + 1);
      chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
      chk($sformatf("tbl%0d_dz", i), dz, tbl[i].dz);
      @(negedge clk);
      chk($sformatf("tbl%0d_idle", i), bus.ready_mdu_o, 1);
      chk($sformatf("tbl%0d_nodone", i), bus.done_mdu_o, 0);
      chk($sformatf("tbl%0d_hold_hi", i), bus.hi_mdu_o, tbl[i].hi);
      chk($sformatf("tbl%0d_hold_dz", i), bus.dz_mdu_o, tbl[i].dz);
    end

    // Start held through the whole op must not retrigger.
    run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b1,
           hi, lo, dz, lat, rl);
    chk("hold_busy", rl, W + 1);
    chk("hold_hi", hi, 32'hFFFF_FFFF);
    chk("hold_lo", lo, 32'hFFFF_FFEB);
    repeat (2) begin
      @(negedge clk);
      chk("hold_ready", bus.ready_mdu_o, 1);
    end

    // dz is sticky until the next accept.
    run_op(2'b11, 32'h1234, 32'd0, 1'b0, hi, lo, dz, lat, rl);
    repeat (3) @(negedge clk);
    chk("dz_sticky", bus.dz_mdu_o, 1);
    bus.start_mdu_i = 1'b1;
    bus.op_mdu_i    = 2'b11;
    bus.opr_a_mdu_i = 32'd7;
    bus.opr_b_mdu_i = 32'd2;
    @(negedge clk);
    bus.start_mdu_i = 1'b0;
    chk("dz_clear", bus.dz_mdu_o, 0);
    chk("dz_busy", bus.ready_mdu_o, 0);
    dn = 0;
    for (int i = 0; i < 100 && !bus.done_mdu_o; i++)
      @(negedge clk);
    chk("dz_next_lo", bus.lo_mdu_o, 32'd3);

    // Reset during iteration 10 of a MULT.
    run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0, hi, lo, dz, lat, rl);
    @(negedge clk);
    bus.start_mdu_i = 1'b1;
    bus.op_mdu_i    = 2'b00;
    bus.opr_a_mdu_i = 32'h1234_5678;
    bus.opr_b_mdu_i = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start_mdu_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", bus.ready_mdu_o, 1);
    chk("mrst_done", bus.done_mdu_o, 0);
    chk("mrst_hi", bus.hi_mdu_o, 0);
    chk("mrst_lo", bus.lo_mdu_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_mdu_o) dn++;
    end
    chk("mrst_nodone", dn, 0);

`ifdef MDU_FLUSH_EN
    run_op(2'b11, 32'd47, 32'd7, 1'b0, hi, lo, dz, lat, rl);
    chk("fl_pre_hi", hi, 32'd5);
    chk("fl_pre_lo", lo, 32'd6);
    @(negedge clk);
    bus.start_mdu_i = 1'b1;
    bus.op_mdu_i    = 2'b11;
    bus.opr_a_mdu_i = 32'd100;
    bus.opr_b_mdu_i = 32'd3;
    @(negedge clk);
    bus.start_mdu_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.flush_mdu_i = 1'b1;
    bus.start_mdu_i = 1'b1;
    #1;
    chk("fl_done_now", bus.done_mdu_o, 0);
    @(negedge clk);
    bus.flush_mdu_i = 1'b0;
    bus.start_mdu_i = 1'b0;
    chk("fl_ready", bus.ready_mdu_o, 1);
    chk("fl_hi", bus.hi_mdu_o, 32'd5);
    chk("fl_lo", bus.lo_mdu_o, 32'd6);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_mdu_o) dn++;
    end
    chk("fl_nodone", dn, 0);
`endif

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = MIN;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 20);
        4: b = -$urandom_range(1, 20);
        default: ;
      endcase
      model(op, a, b, ehi, elo, edz);
      run_op(op, a, b, 1'b0, hi, lo, dz, lat, rl);
      chk($sformatf("rnd%0d_lat", i), lat, W + 1);
      chk($sformatf("rnd%0d_res op=%0d a=%h b=%h", i, op, a, b),
          {hi, lo}, {ehi, elo});
      chk($sformatf("rnd%0d_dz", i), dz, edz);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
